sum8_dma: RTL and testbench

SUM8_DMA -- requirements
Module: sum8_dma

---
 rtl/sum8_dma.sv | 129 ++++++++++++
 tb/tb_sum8_dma.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum8_dma.sv
// sum8_dma: reads len 256-bit words over an IOb master port, adds up every signed
// 32-bit lane of every word and writes the 32-bit total to a destination word.
module sum8_dma #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 256,
    parameter int LEN_W  = 16
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  start_i,
    input  logic [ADDR_W-1:0]     src_addr_i,
    input  logic [LEN_W-1:0]      len_i,
    input  logic [ADDR_W-1:0]     dst_addr_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [31:0]           sum_o,
    output logic                  iob_valid_o,
    output logic [ADDR_W-1:0]     iob_addr_o,
    output logic [DATA_W-1:0]     iob_wdata_o,
    output logic [DATA_W/8-1:0]   iob_wstrb_o,
    input  logic [DATA_W-1:0]     iob_rdata_i,
    input  logic                  iob_rvalid_i,
    input  logic                  iob_ready_i
);
    localparam int LANES = DATA_W / 32;
    localparam logic [DATA_W/8-1:0] WR_STRB = {{(DATA_W/8-4){1'b0}}, 4'hF};

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx;
    logic [LEN_W-1:0]  idx_next;
    logic [31:0]       acc;
    logic [31:0]       acc_next;
    logic [31:0]       lane_sum;

    // Two's complement lanes wrap naturally when summed as unsigned 32-bit values.
    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_sum = lane_sum + iob_rdata_i[32*k +: 32];
        end
    end

    assign acc_next = acc + lane_sum;
    assign idx_next = idx + LEN_W'(1);

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state       <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            idx         <= '0;
            acc         <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            sum_o       <= '0;
            iob_valid_o <= 1'b0;
            iob_addr_o  <= '0;
            iob_wdata_o <= '0;
            iob_wstrb_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        src_q       <= src_addr_i;
                        len_q       <= len_i;
                        dst_q       <= dst_addr_i;
                        acc         <= '0;
                        idx         <= '0;
                        busy_o      <= 1'b1;
                        iob_valid_o <= 1'b1;
                        if (len_i != '0) begin
                            state       <= RD_REQ;
                            iob_addr_o  <= src_addr_i;
                            iob_wstrb_o <= '0;
                        end else begin
                            state       <= WR_REQ;
                            iob_addr_o  <= dst_addr_i;
                            iob_wdata_o <= '0;
                            iob_wstrb_o <= WR_STRB;
                        end
                    end
                end
                RD_REQ: begin
                    if (iob_ready_i) begin
                        iob_valid_o <= 1'b0;
                        state       <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (iob_rvalid_i) begin
                        acc         <= acc_next;
                        idx         <= idx_next;
                        iob_valid_o <= 1'b1;
                        if (idx == len_q - LEN_W'(1)) begin
                            state       <= WR_REQ;
                            iob_addr_o  <= dst_q;
                            iob_wdata_o <= DATA_W'(acc_next);
                            iob_wstrb_o <= WR_STRB;
                        end else begin
                            state      <= RD_REQ;
                            iob_addr_o <= src_q + ADDR_W'(idx_next);
                        end
                    end
                end
                WR_REQ: begin
                    if (iob_ready_i) begin
                        iob_valid_o <= 1'b0;
                        iob_wstrb_o <= '0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    done_o <= 1'b1;
                    sum_o  <= acc;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sum8_dma.sv
// tb_sum8_dma: directed vectors for sum8_dma against a small IOb memory responder
// with configurable ready and rvalid delays.
module tb_sum8_dma;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 256;
    localparam int LEN_W  = 16;

    logic                clk = 1'b0;
    logic                arst_i;
    logic                start_i;
    logic [ADDR_W-1:0]   src_addr_i;
    logic [LEN_W-1:0]    len_i;
    logic [ADDR_W-1:0]   dst_addr_i;
    logic                busy_o;
    logic                done_o;
    logic [31:0]         sum_o;
    logic                iob_valid_o;
    logic [ADDR_W-1:0]   iob_addr_o;
    logic [DATA_W-1:0]   iob_wdata_o;
    logic [DATA_W/8-1:0] iob_wstrb_o;
    logic [DATA_W-1:0]   iob_rdata_i = '0;
    logic                iob_rvalid_i = 1'b0;
    logic                iob_ready_i = 1'b0;

    always #5 clk = ~clk;

    sum8_dma #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk_i(clk), .arst_i(arst_i), .start_i(start_i),
        .src_addr_i(src_addr_i), .len_i(len_i), .dst_addr_i(dst_addr_i),
        .busy_o(busy_o), .done_o(done_o), .sum_o(sum_o),
        .iob_valid_o(iob_valid_o), .iob_addr_o(iob_addr_o),
        .iob_wdata_o(iob_wdata_o), .iob_wstrb_o(iob_wstrb_o),
        .iob_rdata_i(iob_rdata_i), .iob_rvalid_i(iob_rvalid_i), .iob_ready_i(iob_ready_i)
    );

    typedef struct {
        logic [ADDR_W-1:0] src;
        logic [LEN_W-1:0]  len;
        logic [ADDR_W-1:0] dst;
        int                base;
        int                step;
        logic [31:0]       expSum;
        int                expLat;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] strb;
    } wr_t;

    int checks = 0;
    int errors = 0;
    int readyDelay = 0;
    int rvalidDelay = 1;
    bit spurious = 1'b0;

    logic [DATA_W-1:0] mem [int unsigned];
    logic [ADDR_W-1:0] rdLog [$];
    wr_t               wrLog [$];

    bit                  prevValid = 1'b0;
    bit                  prevReady = 1'b0;
    logic [ADDR_W-1:0]   prevAddr;
    logic [DATA_W-1:0]   prevWdata;
    logic [DATA_W/8-1:0] prevWstrb;
    int                  reqAge = 0;
    bit                  pending = 1'b0;
    logic [ADDR_W-1:0]   pendAddr;
    int                  pendCnt = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [DATA_W-1:0] memRead(input logic [ADDR_W-1:0] a);
        return mem.exists(32'(a)) ? mem[32'(a)] : '0;
    endfunction

    // Memory responder: acts at negedges on what the DUT presented during the cycle.
    always @(negedge clk) begin
        if (prevValid && prevReady) begin
            if (prevWstrb == '0) begin
                checkOutput("one_outstanding", 64'(pending), 64'd0);
                rdLog.push_back(prevAddr);
                pending  = 1'b1;
                pendAddr = prevAddr;
                pendCnt  = rvalidDelay;
            end else begin
                wrLog.push_back('{addr: prevAddr, data: prevWdata, strb: prevWstrb});
            end
        end else if (prevValid && !arst_i) begin
            checkOutput("req_held_valid", 64'(iob_valid_o), 64'd1);
            checkOutput("req_held_addr", 64'(iob_addr_o), 64'(prevAddr));
            checkOutput("req_held_wstrb", 64'(iob_wstrb_o), 64'(prevWstrb));
            checkOutput("req_held_wdata", 64'(iob_wdata_o == prevWdata), 64'd1);
        end
        if (pending) checkOutput("no_req_while_pending", 64'(iob_valid_o), 64'd0);
        iob_rvalid_i = 1'b0;
        if (pending) begin
            pendCnt--;
            if (pendCnt <= 0) begin
                iob_rvalid_i = 1'b1;
                iob_rdata_i  = memRead(pendAddr);
                pending      = 1'b0;
            end
        end
        if (spurious) begin
            iob_rvalid_i = 1'b1;
            iob_rdata_i  = '1;
            spurious     = 1'b0;
        end
        reqAge      = iob_valid_o ? reqAge + 1 : 0;
        iob_ready_i = iob_valid_o && (reqAge > readyDelay);
        prevValid   = iob_valid_o;
        prevReady   = iob_ready_i;
        prevAddr    = iob_addr_o;
        prevWdata   = iob_wdata_o;
        prevWstrb   = iob_wstrb_o;
    end

    task automatic fillMem(input vec_t v);
        logic [DATA_W-1:0] word;
        logic [ADDR_W-1:0] a;
        mem.delete();
        for (int w = 0; w < int'(v.len); w++) begin
            a = v.src + ADDR_W'(w);
            for (int k = 0; k < 8; k++) word[32*k +: 32] = 32'(v.base + v.step * (w * 8 + k));
            mem[32'(a)] = word;
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [ADDR_W-1:0] s,
                                 input logic [LEN_W-1:0] l, input logic [ADDR_W-1:0] d);
        start_i = st; src_addr_i = s; len_i = l; dst_addr_i = d;
    endtask

    task automatic runJob(input vec_t v, input bit midStart);
        int lat;
        logic [ADDR_W-1:0] ea;
        fillMem(v);
        rdLog.delete();
        wrLog.delete();
        @(negedge clk);
        applyStimulus(1'b1, v.src, v.len, v.dst);
        @(posedge clk); #1;
        start_i = 1'b0;
        lat = 0;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            if (midStart && c == 3) applyStimulus(1'b1, 19'h00100, 16'd1, 19'h00200);
            if (midStart && c == 4) start_i = 1'b0;
            if (done_o) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) checkOutput("done_timeout", 64'd0, 64'd1);
        else if (v.expLat > 0) checkOutput("latency", 64'(lat), 64'(v.expLat));
        checkOutput("sum", 64'(sum_o), 64'(v.expSum));
        checkOutput("busy_at_done", 64'(busy_o), 64'd0);
        checkOutput("read_count", 64'(rdLog.size()), 64'(v.len));
        for (int w = 0; w < rdLog.size(); w++) begin
            ea = v.src + ADDR_W'(w);
            checkOutput("read_addr", 64'(rdLog[w]), 64'(ea));
        end
        checkOutput("write_count", 64'(wrLog.size()), 64'd1);
        if (wrLog.size() >= 1) begin
            checkOutput("write_addr", 64'(wrLog[0].addr), 64'(v.dst));
            checkOutput("write_data", 64'(wrLog[0].data[31:0]), 64'(v.expSum));
            checkOutput("write_upper_zero", 64'(|wrLog[0].data[DATA_W-1:32]), 64'd0);
            checkOutput("write_strb", 64'(wrLog[0].strb), 64'h0000000F);
        end
        @(posedge clk); #1;
        checkOutput("done_one_cycle", 64'(done_o), 64'd0);
        checkOutput("sum_hold", 64'(sum_o), 64'(v.expSum));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, 64'(busy_o), 64'd0);
        checkOutput({tag, "_done"}, 64'(done_o), 64'd0);
        checkOutput({tag, "_valid"}, 64'(iob_valid_o), 64'd0);
        checkOutput({tag, "_addr"}, 64'(iob_addr_o), 64'd0);
        checkOutput({tag, "_wdata"}, 64'(|iob_wdata_o), 64'd0);
        checkOutput({tag, "_wstrb"}, 64'(iob_wstrb_o), 64'd0);
        checkOutput({tag, "_sum"}, 64'(sum_o), 64'd0);
    endtask

    vec_t vecs [6];
    vec_t slow;

    initial begin
        vecs[0] = '{src: 19'h00005, len: 16'd1, dst: 19'h00010, base: 1, step: 1, expSum: 32'd36, expLat: 4};
        vecs[1] = '{src: 19'h00005, len: 16'd3, dst: 19'h00010, base: -1, step: 0, expSum: 32'hFFFFFFE8, expLat: 8};
        vecs[2] = '{src: 19'h00005, len: 16'd1, dst: 19'h00010, base: 32'h7FFFFFFF, step: 0, expSum: 32'hFFFFFFF8, expLat: 4};
        vecs[3] = '{src: 19'h00005, len: 16'd0, dst: 19'h00010, base: 0, step: 0, expSum: 32'd0, expLat: 2};
        vecs[4] = '{src: 19'h7FFFF, len: 16'd2, dst: 19'h00030, base: 1, step: 1, expSum: 32'd136, expLat: 6};
        vecs[5] = '{src: 19'h00020, len: 16'd2, dst: 19'h00040, base: 10, step: -3, expSum: 32'hFFFFFF38, expLat: 6};

        arst_i = 1'b1;
        applyStimulus(1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        @(negedge clk);
        arst_i = 1'b0;

        for (int i = 0; i < 6; i++) runJob(vecs[i], 1'b0);

        // Slow slave: request fields must stay put while ready is low.
        slow = vecs[1];
        slow.expLat = 0;
        readyDelay = 5;
        rvalidDelay = 3;
        runJob(slow, 1'b0);
        readyDelay = 0;
        rvalidDelay = 1;

        runJob(vecs[1], 1'b1);

        @(posedge clk); #1;
        spurious = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("idle_after_spurious_rvalid", 64'(busy_o), 64'd0);
        runJob(vecs[0], 1'b0);

        // Reset while a read response is still outstanding.
        rvalidDelay = 3;
        fillMem(vecs[1]);
        rdLog.delete();
        @(negedge clk);
        applyStimulus(1'b1, vecs[1].src, vecs[1].len, vecs[1].dst);
        @(posedge clk); #1;
        start_i = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk); #2;
                if (rdLog.size() >= 1) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) checkOutput("rd_accept_timeout", 64'd0, 64'd1);
        end
        arst_i = 1'b1;
        @(posedge clk); #1;
        arst_i = 1'b0;
        checkResetOutputs("midjob_reset");
        repeat (5) @(posedge clk);
        #1;
        checkOutput("late_rvalid_busy", 64'(busy_o), 64'd0);
        checkOutput("late_rvalid_sum", 64'(sum_o), 64'd0);
        checkOutput("late_rvalid_reads", 64'(rdLog.size()), 64'd1);
        rvalidDelay = 1;
        runJob(vecs[0], 1'b0);

        rdLog.delete();
        @(negedge clk);
        arst_i = 1'b1;
        applyStimulus(1'b1, 19'h00005, 16'd1, 19'h00010);
        @(posedge clk); #1;
        arst_i = 1'b0;
        start_i = 1'b0;
        checkOutput("reset_beats_start_busy", 64'(busy_o), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_beats_start_idle", 64'(busy_o), 64'd0);
        checkOutput("reset_beats_start_reads", 64'(rdLog.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
